// File: rtl/rv32ima_pkg.sv
// Shared types for the RV32IMA front end.
// Fetch state encoding and instruction queue entry.
package rv32ima_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DROP
  } fetch_state_t;

  typedef struct packed {
    word_t inst;
    word_t pc;
  } fq_entry_t;

  function automatic word_t word_align(word_t a);
    return a & ~32'h3;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small FIFO of fetched {inst, pc} pairs.
// Push into a full queue succeeds when a pop happens in the same cycle.
module fetch_queue
  import rv32ima_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  fq_entry_t     push_data,
  input  logic          pop,
  output fq_entry_t     head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  fq_entry_t     mem_q [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr] <= push_data;
        wr_ptr        <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

  assign head  = mem_q[rd_ptr];
  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);
  assign count = cnt;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding imem request,
// responses buffered in fetch_queue, redirect flushes.
module fetch_unit
  import rv32ima_pkg::*;
#(
  parameter word_t RESET_PC = 32'h0000_0000,
  parameter int    QDEPTH   = 2
) (
  input  logic        CLK,
  input  logic        nRST,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
);

  localparam int          CW      = $clog2(QDEPTH) + 1;
  localparam int          LW      = CW + 1;
  localparam logic [CW:0] DEPTH_L = LW'(QDEPTH);

  fetch_state_t  state_q;
  fetch_state_t  state_d;
  word_t         fetch_pc;
  word_t         req_pc;
  logic          grant;
  logic          can_issue;
  logic          q_push;
  logic          q_pop;
  logic          q_full;
  logic          q_empty;
  logic          q_room;
  logic [CW-1:0] q_count;
  logic [CW:0]   q_level;
  fq_entry_t     q_in;
  fq_entry_t     q_head;

  assign grant  = imem_req && imem_gnt;
  assign q_push = (state_q == WAIT) && imem_rvalid
                  && !redirect_valid;
  assign q_pop  = !q_empty && inst_ready && !redirect_valid;

  // Occupancy after this cycle's push/pop decides issue.
  assign q_level = {1'b0, q_count} + LW'(q_push) - LW'(q_pop);
  assign q_room  = q_full ? (q_pop && !q_push)
                          : (q_level < DEPTH_L);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (grant) state_d = WAIT;
      end
      WAIT: begin
        if (redirect_valid) begin
          state_d = imem_rvalid ? IDLE : DROP;
        end else if (imem_rvalid) begin
          state_d = grant ? WAIT : IDLE;
        end
      end
      DROP: begin
        if (imem_rvalid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    can_issue = 1'b0;
    unique case (state_q)
      IDLE:    can_issue = 1'b1;
      WAIT:    can_issue = imem_rvalid;
      default: can_issue = 1'b0;
    endcase
    imem_req = nRST && !redirect_valid
               && can_issue && q_room;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      fetch_pc <= RESET_PC;
      req_pc   <= RESET_PC;
    end else if (redirect_valid) begin
      fetch_pc <= word_align(redirect_pc);
    end else if (grant) begin
      fetch_pc <= fetch_pc + 32'd4;
      req_pc   <= fetch_pc;
    end
  end

  assign imem_addr = word_align(fetch_pc);
  assign q_in.inst = imem_rdata;
  assign q_in.pc   = req_pc;

  fetch_queue #(
    .DEPTH(QDEPTH)
  ) u_queue (
    .clk      (CLK),
    .rst_n    (nRST),
    .flush    (redirect_valid),
    .push     (q_push),
    .push_data(q_in),
    .pop      (q_pop),
    .head     (q_head),
    .full     (q_full),
    .empty    (q_empty),
    .count    (q_count)
  );

  assign inst_valid = !q_empty;
  assign inst       = q_head.inst;
  assign inst_pc    = q_head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed tables,
// corner sequences and randomized traffic vs a queue model.
module tb_fetch_unit;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        inst_ready = 1'b0;

  logic        req_a, req_b, val_a, val_b;
  logic [31:0] addr_a, addr_b, inst_a, inst_b, ipc_a, ipc_b;
  logic        imem_req, inst_valid;
  logic [31:0] imem_addr, inst, inst_pc;
  bit          sel = 1'b0;

  always #5 CLK = ~CLK;

  fetch_unit u_dut_a (
    .CLK(CLK), .nRST(nRST),
    .imem_req(req_a), .imem_addr(addr_a),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .inst_valid(val_a), .inst(inst_a), .inst_pc(ipc_a),
    .inst_ready(inst_ready)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) u_dut_b (
    .CLK(CLK), .nRST(nRST),
    .imem_req(req_b), .imem_addr(addr_b),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .inst_valid(val_b), .inst(inst_b), .inst_pc(ipc_b),
    .inst_ready(inst_ready)
  );

  always_comb begin
    imem_req   = sel ? req_b  : req_a;
    imem_addr  = sel ? addr_b : addr_a;
    inst_valid = sel ? val_b  : val_a;
    inst       = sel ? inst_b : inst_a;
    inst_pc    = sel ? ipc_b  : ipc_a;
  end

  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          stale;
  } pend_t;

  typedef struct {
    bit          rst;
    bit          gnt;
    bit          rdy;
    bit          rdr;
    logic [31:0] rpc;
    int          lat;
    bit          e_req;
    logic [31:0] e_addr;
    bit          e_valid;
    logic [31:0] e_pc;
  } vec_t;

  pend_t       pend[$];
  logic [31:0] mq[$];
  logic [31:0] pop_log[$];
  vec_t        tbl[$];
  int          cyc, lat, n_chk, n_pass;
  logic [31:0] exp_addr, exp_pop;
  bit          rsp_en, junk_rsp;
  bit          prev_req, prev_gnt, prev_rdr;
  logic [31:0] prev_addr;
  bit          s_req, s_valid;
  logic [31:0] s_addr, s_pc;

  function automatic logic [31:0] memf(logic [31:0] a);
    return a ^ 32'h5A5A_0F0F ^ {a[15:0], a[31:16]};
  endfunction

  function automatic logic [31:0] plog(int i);
    return (pop_log.size() > i) ? pop_log[i] : 32'hBAD0_0000;
  endfunction

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h (cycle %0d)",
                  nm, act, exp, cyc);
  endtask

  task automatic do_reset();
    logic [31:0] rp;
    rp = sel ? 32'hFFFF_FFF8 : 32'h0;
    @(negedge CLK);
    nRST = 1'b0;
    imem_gnt = 1'b0;
    imem_rvalid = 1'b0;
    inst_ready = 1'b0;
    redirect_valid = 1'b0;
    #1;
    chk("rst_req", imem_req, 0);
    chk("rst_valid", inst_valid, 0);
    chk("rst_inst", inst, 0);
    chk("rst_inst_pc", inst_pc, 0);
    chk("rst_addr", imem_addr, rp);
    repeat (2) @(posedge CLK);
    pend.delete();
    mq.delete();
    pop_log.delete();
    exp_addr = rp;
    exp_pop  = rp;
    prev_req = 1'b0;
    cyc = 0;
  endtask

  task automatic cycle(bit gnt, bit rdy, bit rdr,
                       logic [31:0] rpc);
    bit    rsp, pop, g;
    pend_t p;
    @(negedge CLK);
    nRST = 1'b1;
    imem_gnt = gnt;
    inst_ready = rdy;
    redirect_valid = rdr;
    redirect_pc = rpc;
    rsp = rsp_en && pend.size() > 0 && pend[0].due <= cyc;
    if (junk_rsp) begin
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hDEAD_BEEF;
    end else begin
      imem_rvalid = rsp;
      imem_rdata  = rsp ? memf(pend[0].addr) : $urandom;
    end
    #1;
    chk("inst_valid", inst_valid, mq.size() != 0);
    chk("addr_align", {30'd0, imem_addr[1:0]}, 0);
    if (rdr) chk("req_on_redirect", imem_req, 0);
    if (imem_req)
      chk("one_outstanding", pend.size() - int'(rsp), 0);
    if (prev_req && !prev_gnt && !prev_rdr && !rdr) begin
      chk("req_stable", imem_req, 1);
      chk("addr_stable", imem_addr, prev_addr);
    end
    g = imem_req && gnt;
    if (g) chk("fetch_addr", imem_addr, exp_addr);
    pop = inst_valid && rdy && !rdr;
    if (pop) begin
      chk("inst_pc", inst_pc, exp_pop);
      chk("inst", inst, memf(exp_pop));
      pop_log.push_back(inst_pc);
      exp_pop += 32'd4;
    end
    s_req = imem_req;
    s_valid = inst_valid;
    s_addr = imem_addr;
    s_pc = inst_pc;
    prev_req = imem_req;
    prev_gnt = gnt;
    prev_rdr = rdr;
    prev_addr = imem_addr;
    if (rsp) begin
      p = pend.pop_front();
      if (!p.stale && !rdr) mq.push_back(p.addr);
    end
    if (pop && mq.size() > 0) void'(mq.pop_front());
    if (rdr) begin
      mq.delete();
      foreach (pend[i]) pend[i].stale = 1'b1;
      exp_addr = rpc & ~32'h3;
      exp_pop  = rpc & ~32'h3;
    end else if (g) begin
      pend.push_back('{imem_addr, cyc + lat, 1'b0});
      exp_addr += 32'd4;
    end
    chk("occupancy", mq.size() > 2, 0);
    cyc++;
  endtask

  task automatic row(bit r, bit gn, bit rd, bit rr,
                     logic [31:0] rp, int lt, bit er,
                     logic [31:0] ea, bit ev,
                     logic [31:0] ep);
    tbl.push_back('{r, gn, rd, rr, rp, lt, er, ea, ev, ep});
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    rsp_en = 1'b1;
    junk_rsp = 1'b0;
    lat = 1;

    // Redirect coincident with rvalid and pop.
    row(1, 1, 1, 0, 0,            1, 1, 32'h0,    0, 0);
    row(0, 1, 1, 0, 0,            1, 1, 32'h4,    0, 0);
    row(0, 1, 1, 0, 0,            1, 1, 32'h8,    1, 32'h0);
    row(0, 1, 1, 1, 32'h1002,     1, 0, 0,        1, 32'h4);
    row(0, 1, 1, 0, 0,            1, 1, 32'h1000, 0, 0);
    row(0, 1, 1, 0, 0,            1, 1, 32'h1004, 0, 0);
    row(0, 1, 1, 0, 0,            1, 1, 32'h1008, 1, 32'h1000);
    // Redirect while the request to 0x8 is outstanding.
    row(1, 1, 1, 0, 0,            2, 1, 32'h0,    0, 0);
    row(0, 1, 1, 0, 0,            2, 0, 0,        0, 0);
    row(0, 1, 1, 0, 0,            2, 1, 32'h4,    0, 0);
    row(0, 1, 1, 0, 0,            2, 0, 0,        1, 32'h0);
    row(0, 1, 1, 0, 0,            2, 1, 32'h8,    0, 0);
    row(0, 1, 1, 1, 32'h1002,     2, 0, 0,        1, 32'h4);
    row(0, 1, 1, 0, 0,            2, 0, 0,        0, 0);
    row(0, 1, 1, 0, 0,            2, 1, 32'h1000, 0, 0);
    row(0, 1, 1, 0, 0,            2, 0, 0,        0, 0);
    row(0, 1, 1, 0, 0,            2, 1, 32'h1004, 0, 0);
    row(0, 1, 1, 0, 0,            2, 0, 0,        1, 32'h1000);

    sel = 1'b0;
    foreach (tbl[i]) begin
      lat = tbl[i].lat;
      if (tbl[i].rst) do_reset();
      cycle(tbl[i].gnt, tbl[i].rdy, tbl[i].rdr, tbl[i].rpc);
      chk("tbl_req", s_req, tbl[i].e_req);
      if (tbl[i].e_req) chk("tbl_addr", s_addr, tbl[i].e_addr);
      chk("tbl_valid", s_valid, tbl[i].e_valid);
      if (tbl[i].e_valid) chk("tbl_pc", s_pc, tbl[i].e_pc);
    end

    // Back-to-back streaming.
    lat = 1;
    do_reset();
    repeat (20) cycle(1, 1, 0, 0);
    chk("b2b_pops", pop_log.size(), 18);

    // Decoder stall fills the queue, then drains in order.
    do_reset();
    repeat (10) cycle(1, 0, 0, 0);
    chk("stall_req", s_req, 0);
    chk("stall_valid", s_valid, 1);
    chk("stall_outstanding", pend.size(), 0);
    repeat (3) cycle(0, 1, 0, 0);
    chk("stall_buffered", pop_log.size(), 2);
    repeat (4) cycle(1, 1, 0, 0);
    chk("stall_pc0", plog(0), 32'h0);
    chk("stall_pc1", plog(1), 32'h4);
    chk("stall_pc2", plog(2), 32'h8);

    // PC wrap from the top of the address space.
    sel = 1'b1;
    do_reset();
    repeat (8) cycle(1, 1, 0, 0);
    chk("wrap_pc0", plog(0), 32'hFFFF_FFF8);
    chk("wrap_pc1", plog(1), 32'hFFFF_FFFC);
    chk("wrap_pc2", plog(2), 32'h0000_0000);

    // Reset mid-request, stray response after release.
    sel = 1'b0;
    lat = 3;
    do_reset();
    cycle(1, 1, 0, 0);
    cycle(1, 1, 0, 0);
    do_reset();
    lat = 1;
    junk_rsp = 1'b1;
    cycle(1, 1, 0, 0);
    junk_rsp = 1'b0;
    cycle(1, 1, 0, 0);
    chk("late_rsp_valid", s_valid, 0);
    repeat (4) cycle(1, 1, 0, 0);
    chk("late_first_pc", plog(0), 32'h0);

    // Randomized traffic on both instances.
    for (int k = 0; k < 2; k++) begin
      sel = (k == 1);
      do_reset();
      for (int n = 0; n < 2000; n++) begin
        logic [31:0] rpc;
        lat = $urandom_range(1, 3);
        rsp_en = ($urandom_range(0, 3) != 0);
        rpc = ($urandom_range(0, 1) != 0) ? $urandom
              : (32'hFFFF_FFF0 | $urandom_range(0, 15));
        cycle($urandom_range(0, 3) != 0,
              $urandom_range(0, 9) < 6,
              $urandom_range(0, 39) == 0, rpc);
      end
      rsp_en = 1'b1;
      chk("rand_progress", pop_log.size() > 100, 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC loaded on reset.
REQ-002 SHALL have parameter QDEPTH, default 2, meaning the instruction queue depth (power of two, >=2).
REQ-003 CLK  input  1  single clock; all state updates on its rising edge.
REQ-004 nRST  input  1  reset; asynchronous, active-low.
REQ-005 imem_req  output  1  instruction memory request valid.
REQ-006 imem_addr  output  32  word-aligned fetch address; bits [1:0] always 0.
REQ-007 imem_gnt  input  1  request accepted when imem_req && imem_gnt.
REQ-008 imem_rvalid  input  1  response data valid; responses arrive in order, >=1 cycle after grant.
REQ-009 imem_rdata  input  32  instruction word.
REQ-010 redirect_valid  input  1  PC redirect from branch/jump/trap resolution.
REQ-011 redirect_pc  input  32  redirect target; bits [1:0] ignored, treated as 0.
REQ-012 inst_valid  output  1  instruction available to the decoder (control unit).
REQ-013 inst  output  32  instruction word to the decoder.
REQ-014 inst_pc  output  32  PC of inst.
REQ-015 inst_ready  input  1  decoder accepts when inst_valid && inst_ready.

Function
REQ-016 SHALL keep fetch_pc, the address of the next request; it advances by 4 on each grant.
REQ-017 SHALL allow at most one outstanding (granted, unanswered) request.
REQ-018 SHALL assert imem_req only when no request is outstanding and (queue count + 0) < QDEPTH; imem_req and imem_addr stay stable until granted unless a redirect occurs.
REQ-019 SHALL use states IDLE (no outstanding request), WAIT (request outstanding, response kept) and DROP (request outstanding, response discarded).
REQ-020 IDLE->WAIT on grant; WAIT->IDLE on imem_rvalid without a same-cycle grant; WAIT->WAIT on rvalid with a same-cycle grant; WAIT->DROP on redirect without rvalid; DROP->IDLE on rvalid.
REQ-021 In WAIT, imem_rvalid SHALL push {imem_rdata, pc of that request} into the queue; in DROP, the response SHALL be discarded.
REQ-022 inst_valid SHALL equal queue non-empty; inst/inst_pc SHALL come from the queue head (registered, no combinational path from imem_rdata).
REQ-023 Latency: a response pushed in cycle N SHALL appear at inst_valid in cycle N+1.
REQ-024 Pop and push in the same cycle SHALL both succeed when the queue is full; count is unchanged.
REQ-025 On redirect_valid: the queue SHALL be flushed, fetch_pc SHALL load {redirect_pc[31:2],2'b00}, any same-cycle pop is ignored, any same-cycle rvalid is discarded, and any same-cycle request is not counted as granted (imem_req SHALL be forced 0 that cycle).
REQ-026 A redirect while in DROP SHALL keep DROP and update fetch_pc to the newer target.
REQ-027 No request SHALL issue while in DROP; the first post-redirect request issues no earlier than the cycle after the redirect.
REQ-028 fetch_pc SHALL wrap from 32'hFFFF_FFFC to 32'h0000_0000 without error.

Reset
REQ-029 On nRST low: fetch_pc=RESET_PC, state=IDLE, queue empty, imem_req=0, inst_valid=0, inst=0, inst_pc=0, imem_addr=RESET_PC.
REQ-030 Reset during an outstanding request SHALL abandon it; a response arriving after reset releases SHALL be ignored (state IDLE).
REQ-031 First request SHALL issue in the first cycle after nRST deasserts.

Structure
REQ-032 word_t (32-bit) and fetch_state_t enum {IDLE, WAIT, DROP} SHALL live in rv32ima_pkg; RESET_PC stays a module parameter.
REQ-033 The queue SHALL be sub-module fetch_queue (QDEPTH entries of {inst, pc}, push/pop/flush, full/empty, count).

Verification
REQ-034 Reset, imem_gnt=1, rvalid 1 cycle after grant, inst_ready=1 -> inst_pc 0,4,8,... back-to-back; inst matches memory.
REQ-035 inst_ready=0 for 10 cycles -> exactly QDEPTH=2 instructions buffered, imem_req=0; ready=1 -> PCs 0,4,8 in order, none lost.
REQ-036 Redirect to 32'h0000_1002 while request to 32'h0000_0008 outstanding -> that response dropped, next imem_addr=32'h0000_1000, next inst_pc=32'h0000_1000.
REQ-037 Redirect coincident with rvalid and pop -> queue empty next cycle, rvalid data never appears on inst.
REQ-038 RESET_PC=32'hFFFF_FFF8 -> inst_pc FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-039 nRST asserted during WAIT, late rvalid after release -> no inst_valid from it; first inst_pc=RESET_PC.
